// File: rtl/regfile_pkg.sv
// Shared register-file types and constants for the write-back path.
package regfile_pkg;

    localparam int REG_ADDR_WIDTH = 5;
    localparam int REG_DATA_WIDTH = 32;

    typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [REG_DATA_WIDTH-1:0] reg_data_t;

    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_MEM = 1'b1
    } wb_src_e;

    localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_wb_arb_scoreboard.sv
// Pending-write busy vector; issue sets, register-file write clears.
module wb_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = REG_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  iss_valid,
    input  logic [ADDR_WIDTH-1:0] iss_rd,
    input  logic                  clr_en,
    input  logic [ADDR_WIDTH-1:0] clr_addr,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    output logic                  hazard_rs1,
    output logic                  hazard_rs2
);

    localparam int NREG = 1 << ADDR_WIDTH;

    logic [NREG-1:0] busy;
    logic [NREG-1:0] set_vec;
    logic [NREG-1:0] clr_vec;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (iss_valid) set_vec[iss_rd] = 1'b1;
        if (clr_en) clr_vec[clr_addr] = 1'b1;
        set_vec[0] = 1'b0;
    end

    // Applying the set after the clear lets a same-cycle re-issue win.
    always_ff @(posedge clk) begin
        if (rst) busy <= '0;
        else busy <= (busy & ~clr_vec) | set_vec;
    end

    assign hazard_rs1 = busy[rs1];
    assign hazard_rs2 = busy[rs2];

endmodule

// File: rtl/regfile_wb_arb.sv
// Round-robin write-back arbiter for the register file write port.
// REGFILE_WB_SCOREBOARD_EN adds the pending-write hazard scoreboard.
module regfile_wb_arb
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
    parameter int DATA_WIDTH = REG_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    input  logic [ADDR_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    output logic                  alu_ready,
    input  logic                  mem_valid,
    input  logic [ADDR_WIDTH-1:0] mem_rd,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  iss_valid,
    input  logic [ADDR_WIDTH-1:0] iss_rd,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    output logic                  hazard_rs1,
    output logic                  hazard_rs2
);

    wb_src_e               prio;
    logic                  conflict;
    logic                  xfer;
    logic [ADDR_WIDTH-1:0] sel_rd;
    logic [DATA_WIDTH-1:0] sel_data;

    always_comb begin
        conflict  = alu_valid && mem_valid;
        alu_ready = alu_valid && (!mem_valid || prio == WB_SRC_ALU);
        mem_ready = mem_valid && (!alu_valid || prio == WB_SRC_MEM);
        xfer      = alu_ready || mem_ready;
        sel_rd    = alu_ready ? alu_rd : mem_rd;
        sel_data  = alu_ready ? alu_data : mem_data;
    end

    // Priority moves to the loser of a conflict so it wins the retry.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio    <= WB_SRC_ALU;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            if (conflict)
                prio <= alu_ready ? WB_SRC_MEM : WB_SRC_ALU;
            if (xfer) begin
                wr_en   <= |sel_rd;
                wr_addr <= sel_rd;
                wr_data <= sel_data;
            end else begin
                wr_en <= 1'b0;
            end
        end
    end

`ifdef REGFILE_WB_SCOREBOARD_EN
    wb_scoreboard #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .clr_en    (wr_en),
        .clr_addr  (wr_addr),
        .rs1       (rs1),
        .rs2       (rs2),
        .hazard_rs1(hazard_rs1),
        .hazard_rs2(hazard_rs2)
    );
`else
    logic unused_iss;
    assign unused_iss = ^{iss_valid, iss_rd, rs1, rs2};
    assign hazard_rs1 = 1'b0;
    assign hazard_rs2 = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Self-checking bench for regfile_wb_arb with a write-port scoreboard.
module tb_regfile_wb_arb;

`ifdef REGFILE_WB_SCOREBOARD_EN
    localparam logic SB_ON = 1'b1;
`else
    localparam logic SB_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        alu_ready;
    logic        mem_valid = 1'b0;
    logic [4:0]  mem_rd = '0;
    logic [31:0] mem_data = '0;
    logic        mem_ready;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        iss_valid = 1'b0;
    logic [4:0]  iss_rd = '0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic        hazard_rs1;
    logic        hazard_rs2;

    regfile_wb_arb dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd),
        .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd),
        .mem_data(mem_data), .mem_ready(mem_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .rs1(rs1), .rs2(rs2),
        .hazard_rs1(hazard_rs1), .hazard_rs2(hazard_rs2)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        en;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          failures = 0;
    logic        m_prio = 1'b0;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;
    logic        last_alu_xfer = 1'b0;
    logic        last_mem_xfer = 1'b0;

    task automatic model_reset();
        m_prio = 1'b0;
        m_addr = '0;
        m_data = '0;
        q.delete();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // One clock: check grants, predict the edge, compare after it.
    task automatic tick();
        exp_t e;
        logic ea;
        logic em;
        #1;
        ea = alu_valid && (!mem_valid || m_prio == 1'b0);
        em = mem_valid && (!alu_valid || m_prio == 1'b1);
        checks++;
        if (alu_ready !== ea || mem_ready !== em) begin
            failures++;
            $display("FAIL grant: alu_ready=%b mem_ready=%b want %b %b",
                     alu_ready, mem_ready, ea, em);
        end
        last_alu_xfer = alu_valid && alu_ready;
        last_mem_xfer = mem_valid && mem_ready;
        if (alu_valid && mem_valid) m_prio = ea ? 1'b1 : 1'b0;
        if (ea || em) begin
            m_addr = ea ? alu_rd : mem_rd;
            m_data = ea ? alu_data : mem_data;
            e.en = |m_addr;
        end else begin
            e.en = 1'b0;
        end
        e.addr = m_addr;
        e.data = m_data;
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        checks++;
        if (wr_en !== e.en) begin
            failures++;
            $display("FAIL wr_en: got %b want %b", wr_en, e.en);
        end
        checks++;
        if (wr_addr !== e.addr || wr_data !== e.data) begin
            failures++;
            $display("FAIL wr_port: got %0d/%h want %0d/%h",
                     wr_addr, wr_data, e.addr, e.data);
        end
    endtask

    task automatic test_reset();
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h3333_0000;
        mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'h4444_0000;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (wr_en !== 1'b0 || wr_addr !== 5'd0 || wr_data !== 32'd0) begin
            failures++;
            $display("FAIL reset_out: got %b/%0d/%h want 0/0/0",
                     wr_en, wr_addr, wr_data);
        end
        rst = 1'b0;
        model_reset();
        tick();
        checks++;
        if (!last_alu_xfer || last_mem_xfer) begin
            failures++;
            $display("FAIL reset_first_grant: alu=%b mem=%b want 1 0",
                     last_alu_xfer, last_mem_xfer);
        end
        alu_valid = 1'b0;
        tick();
        mem_valid = 1'b0;
        tick();
    endtask

    task automatic test_single_alu();
        apply_reset();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
        tick();
        alu_valid = 1'b0;
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 5'd5 || wr_data !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL single_alu: got %b/%0d/%h want 1/5/deadbeef",
                     wr_en, wr_addr, wr_data);
        end
        tick();
        tick();
    endtask

    task automatic test_round_robin();
        int order[$];
        apply_reset();
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA1;
        mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 32'hB2;
        for (int c = 0; c < 4 && (alu_valid || mem_valid); c++) begin
            tick();
            if (last_alu_xfer) begin order.push_back(0); alu_valid = 1'b0; end
            if (last_mem_xfer) begin order.push_back(1); mem_valid = 1'b0; end
        end
        checks++;
        if (order.size() != 2 || order[0] != 0 || order[1] != 1) begin
            failures++;
            $display("FAIL rr_first: got %0d grants (first=%0d) want ALU,MEM",
                     order.size(), order.size() > 0 ? order[0] : -1);
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        alu_valid = 1'b1; alu_data = 32'hA3;
        mem_valid = 1'b1; mem_data = 32'hB4;
        tick();
        checks++;
        if (!last_mem_xfer || last_alu_xfer) begin
            failures++;
            $display("FAIL rr_second: alu=%b mem=%b want 0 1",
                     last_alu_xfer, last_mem_xfer);
        end
        mem_valid = 1'b0;
        tick();
        alu_valid = 1'b0;
        tick();
    endtask

    task automatic test_x0_drop();
        mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h1234;
        tick();
        mem_valid = 1'b0;
        checks++;
        if (!last_mem_xfer || wr_en !== 1'b0) begin
            failures++;
            $display("FAIL x0_drop: xfer=%b wr_en=%b want 1 0",
                     last_mem_xfer, wr_en);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int cyc = 0;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h11;
        mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h22;
        while ((alu_valid || mem_valid) && cyc < 4) begin
            tick();
            cyc++;
            if (last_alu_xfer) alu_valid = 1'b0;
            if (last_mem_xfer) mem_valid = 1'b0;
        end
        checks++;
        if (cyc != 2) begin
            failures++;
            $display("FAIL b2b_cycles: got %0d want 2", cyc);
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            if (!alu_valid && ($urandom % 2 == 1)) begin
                alu_valid = 1'b1;
                alu_rd = 5'($urandom);
                alu_data = $urandom;
            end
            if (!mem_valid && ($urandom % 2 == 1)) begin
                mem_valid = 1'b1;
                mem_rd = 5'($urandom);
                mem_data = $urandom;
            end
            tick();
            if (last_alu_xfer) alu_valid = 1'b0;
            if (last_mem_xfer) mem_valid = 1'b0;
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        tick();
    endtask

    task automatic test_scoreboard();
        apply_reset();
        rs1 = 5'd10; rs2 = 5'd0;
        iss_valid = 1'b1; iss_rd = 5'd10;
        tick();
        iss_valid = 1'b0;
        checks++;
        if (hazard_rs1 !== SB_ON || hazard_rs2 !== 1'b0) begin
            failures++;
            $display("FAIL sb_set: hz1=%b hz2=%b want %b 0",
                     hazard_rs1, hazard_rs2, SB_ON);
        end
        alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hA10;
        tick();
        alu_valid = 1'b0;
        checks++;
        if (hazard_rs1 !== SB_ON) begin
            failures++;
            $display("FAIL sb_wr_cycle: got %b want %b", hazard_rs1, SB_ON);
        end
        tick();
        checks++;
        if (hazard_rs1 !== 1'b0) begin
            failures++;
            $display("FAIL sb_clear: got %b want 0", hazard_rs1);
        end
        iss_valid = 1'b1; iss_rd = 5'd10;
        tick();
        iss_valid = 1'b0;
        alu_valid = 1'b1; alu_data = 32'hA11;
        tick();
        alu_valid = 1'b0;
        iss_valid = 1'b1; iss_rd = 5'd10;
        tick();
        iss_valid = 1'b0;
        rs2 = 5'd10;
        #1;
        checks++;
        if (hazard_rs1 !== SB_ON || hazard_rs2 !== SB_ON) begin
            failures++;
            $display("FAIL sb_set_wins: hz1=%b hz2=%b want %b %b",
                     hazard_rs1, hazard_rs2, SB_ON, SB_ON);
        end
        apply_reset();
        checks++;
        if (hazard_rs1 !== 1'b0 || hazard_rs2 !== 1'b0) begin
            failures++;
            $display("FAIL sb_reset: hz1=%b hz2=%b want 0 0",
                     hazard_rs1, hazard_rs2);
        end
    endtask

    initial begin
        test_reset();
        test_single_alu();
        test_round_robin();
        test_x0_drop();
        test_back_to_back();
        test_random();
        test_scoreboard();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
